// File: rtl/aoc_grid_sequencer_if.sv
// aoc_grid_sequencer_if
//
// Groups the byte-stream input handshake and the solver register bus that
// aoc_grid_sequencer talks over.
//
// Signals:
//   in_valid / in_ready / in_data[7:0] / in_last  ASCII grid byte stream
//   solver_clear                                   active-high solver reset
//   reg_addr[3:0] / reg_wdata[31:0]                solver register address / write data
//   reg_write_strobe                               solver write strobe
//   reg_rdata[31:0]                                solver read data, combinational on reg_addr
//
// Modports:
//   master  the sequencer: it consumes the byte stream and drives the solver bus
//   slave   the environment: byte source plus solver
interface aoc_grid_sequencer_if;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  in_data;
    logic        in_last;
    logic        solver_clear;
    logic [3:0]  reg_addr;
    logic [31:0] reg_wdata;
    logic        reg_write_strobe;
    logic [31:0] reg_rdata;

    modport master (
        input  in_valid, in_data, in_last, reg_rdata,
        output in_ready, solver_clear, reg_addr, reg_wdata, reg_write_strobe
    );

    modport slave (
        output in_valid, in_data, in_last, reg_rdata,
        input  in_ready, solver_clear, reg_addr, reg_wdata, reg_write_strobe
    );
endinterface

// File: rtl/aoc_grid_sequencer.sv
// aoc_grid_sequencer
//
// Runs one job on the grid solver register port. The job proceeds as follows:
//   1. Reset the solver.
//   2. Optionally write every cell to 0.
//   3. Turn the ASCII grid stream ('@' = 1, '.' = 0, '\n' = next row) into
//      address/data register write pairs.
//   4. Write START.
//   5. Poll status until the solver reports finished, or until POLL_LIMIT
//      polls have gone by.
//   6. Latch the removal count.
//
// Parameters: GRID_W (columns), GRID_H (rows), POLL_LIMIT (polls before timeout)
//
// Ports:
//   clock    rising-edge clock
//   clear_n  synchronous active-low reset
//   go       job start pulse, honoured only in IDLE or DONE
//   busy     high from go acceptance until DONE
//   done     job finished, held until the next go
//   error    sticky per job: out-of-range cell or poll timeout
//   result   solver count, valid while done
//   bus      master side of aoc_grid_sequencer_if (byte stream + solver bus)
//
// Build option: define AOC_GRID_SEQ_PREZERO_EN to compile in the ZERO state.
// In that state every cell is written 0 before any input is accepted. Without
// it, cells the input does not cover keep whatever the solver RAM already held.
module aoc_grid_sequencer #(
    parameter int GRID_W     = 10,
    parameter int GRID_H     = 10,
    parameter int POLL_LIMIT = 65535
) (
    input  logic                       clock,
    input  logic                       clear_n,
    input  logic                       go,
    output logic                       busy,
    output logic                       done,
    output logic                       error,
    output logic [15:0]                result,
    aoc_grid_sequencer_if.master       bus
);

    localparam int CW = $clog2(GRID_W + 1);
    localparam int RW = $clog2(GRID_H + 1);
    localparam int PW = $clog2(POLL_LIMIT + 1);

    typedef enum logic [3:0] {
        IDLE, CLR, ZERO, ACCEPT, WR_ADDR, WR_DATA, START, POLL, DONE
    } state_t;

    state_t          state_q, state_d;
    logic [RW-1:0]   row_q, row_d;
    logic [CW-1:0]   col_q, col_d;
    logic [31:0]     idx_q, idx_d;
    logic            bit_q, bit_d;
    logic            last_q, last_d;
    logic [PW-1:0]   poll_q, poll_d;
    logic [3:0]      addr_q, addr_d;
    logic [31:0]     wdata_q, wdata_d;
    logic            strobe_q, strobe_d;
    logic            clear_q, clear_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic            error_q, error_d;
    logic [15:0]     result_q, result_d;
`ifdef AOC_GRID_SEQ_PREZERO_EN
    logic [31:0]     zidx_q, zidx_d;
    logic            zphase_q, zphase_d;
`endif

    logic            is_cell;
    logic            in_range;
    logic [31:0]     cell_idx;

    assign is_cell  = (bus.in_data == 8'h40) || (bus.in_data == 8'h2E);
    assign in_range = (col_q < CW'(GRID_W)) && (row_q < RW'(GRID_H));
    assign cell_idx = 32'(row_q) * 32'(GRID_W) + 32'(col_q);

    // in_ready is the only unregistered output; it decodes straight from the state register.
    assign bus.in_ready         = (state_q == ACCEPT);
    assign bus.solver_clear     = clear_q;
    assign bus.reg_addr         = addr_q;
    assign bus.reg_wdata        = wdata_q;
    assign bus.reg_write_strobe = strobe_q;
    assign busy                 = busy_q;
    assign done                 = done_q;
    assign error                = error_q;
    assign result               = result_q;

    // Next-state logic. The bus outputs are then decoded from the *next* state, so that the
    // registered copies line up with the state they belong to.
    always_comb begin
        state_d  = state_q;
        row_d    = row_q;
        col_d    = col_q;
        idx_d    = idx_q;
        bit_d    = bit_q;
        last_d   = last_q;
        poll_d   = poll_q;
        error_d  = error_q;
        result_d = result_q;
`ifdef AOC_GRID_SEQ_PREZERO_EN
        zidx_d   = zidx_q;
        zphase_d = zphase_q;
`endif

        case (state_q)
            IDLE, DONE: begin
                if (go) begin
                    state_d  = CLR;
                    error_d  = 1'b0;
                    result_d = 16'd0;
                end
            end
            CLR: begin
                row_d = '0;
                col_d = '0;
`ifdef AOC_GRID_SEQ_PREZERO_EN
                zidx_d   = 32'd0;
                zphase_d = 1'b0;
                state_d  = ZERO;
`else
                state_d  = ACCEPT;
`endif
            end
`ifdef AOC_GRID_SEQ_PREZERO_EN
            ZERO: begin
                // Phase 0 writes the index register, phase 1 writes the zero data.
                if (zphase_q) begin
                    zphase_d = 1'b0;
                    if (zidx_q == 32'(GRID_W * GRID_H - 1)) begin
                        state_d = ACCEPT;
                    end else begin
                        zidx_d = zidx_q + 32'd1;
                    end
                end else begin
                    zphase_d = 1'b1;
                end
            end
`endif
            ACCEPT: begin
                if (bus.in_valid) begin
                    if (is_cell) begin
                        if (in_range) begin
                            // A pending write delays START until WR_DATA has been issued.
                            idx_d   = cell_idx;
                            bit_d   = (bus.in_data == 8'h40);
                            last_d  = bus.in_last;
                            col_d   = col_q + CW'(1);
                            state_d = WR_ADDR;
                        end else begin
                            error_d = 1'b1;
                            if (col_q < CW'(GRID_W)) begin
                                col_d = col_q + CW'(1);
                            end
                            if (bus.in_last) begin
                                state_d = START;
                            end
                        end
                    end else begin
                        if (bus.in_data == 8'h0A) begin
                            col_d = '0;
                            if (row_q < RW'(GRID_H)) begin
                                row_d = row_q + RW'(1);
                            end
                        end
                        if (bus.in_last) begin
                            state_d = START;
                        end
                    end
                end
            end
            WR_ADDR: state_d = WR_DATA;
            WR_DATA: state_d = last_q ? START : ACCEPT;
            START: begin
                poll_d  = '0;
                state_d = POLL;
            end
            POLL: begin
                if (bus.reg_rdata[0]) begin
                    result_d = bus.reg_rdata[31:16];
                    state_d  = DONE;
                end else if (poll_q == PW'(POLL_LIMIT - 1)) begin
                    error_d  = 1'b1;
                    result_d = 16'd0;
                    state_d  = DONE;
                end else begin
                    poll_d = poll_q + PW'(1);
                end
            end
            default: state_d = IDLE;
        endcase

        addr_d   = 4'd0;
        wdata_d  = 32'd0;
        strobe_d = 1'b0;
        clear_d  = 1'b0;
        case (state_d)
            CLR: clear_d = 1'b1;
`ifdef AOC_GRID_SEQ_PREZERO_EN
            ZERO: begin
                strobe_d = 1'b1;
                if (zphase_d) begin
                    addr_d = 4'd3;
                end else begin
                    addr_d  = 4'd2;
                    wdata_d = zidx_d;
                end
            end
`endif
            WR_ADDR: begin
                addr_d   = 4'd2;
                wdata_d  = idx_d;
                strobe_d = 1'b1;
            end
            WR_DATA: begin
                addr_d   = 4'd3;
                wdata_d  = {31'd0, bit_d};
                strobe_d = 1'b1;
            end
            START: begin
                addr_d   = 4'd0;
                wdata_d  = 32'd1;
                strobe_d = 1'b1;
            end
            POLL: addr_d = 4'd1;
            default: ;
        endcase
        busy_d = (state_d != IDLE) && (state_d != DONE);
        done_d = (state_d == DONE);
    end

    // State and registered outputs. Reset can land in any state, including mid-job.
    always_ff @(posedge clock) begin
        if (!clear_n) begin
            state_q  <= IDLE;
            row_q    <= '0;
            col_q    <= '0;
            idx_q    <= 32'd0;
            bit_q    <= 1'b0;
            last_q   <= 1'b0;
            poll_q   <= '0;
            addr_q   <= 4'd0;
            wdata_q  <= 32'd0;
            strobe_q <= 1'b0;
            clear_q  <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            error_q  <= 1'b0;
            result_q <= 16'd0;
`ifdef AOC_GRID_SEQ_PREZERO_EN
            zidx_q   <= 32'd0;
            zphase_q <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            row_q    <= row_d;
            col_q    <= col_d;
            idx_q    <= idx_d;
            bit_q    <= bit_d;
            last_q   <= last_d;
            poll_q   <= poll_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            strobe_q <= strobe_d;
            clear_q  <= clear_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            error_q  <= error_d;
            result_q <= result_d;
`ifdef AOC_GRID_SEQ_PREZERO_EN
            zidx_q   <= zidx_d;
            zphase_q <= zphase_d;
`endif
        end
    end

endmodule

// File: tb/tb_aoc_grid_sequencer.sv
// tb_aoc_grid_sequencer
//
// Directed bench for aoc_grid_sequencer. A behavioural solver sits on the register bus.
// Its finish mode is selectable:
//   - report a fixed count,
//   - compute the removal count from its RAM, or
//   - never finish.
// The stimulus side queues the expected register writes and the expected job outcome.
// A negedge monitor pops those queues whenever the DUT strobes a write or raises done.
module tb_aoc_grid_sequencer;

    localparam int GW    = 10;
    localparam int GH    = 10;
    localparam int PL    = 16;
    localparam int CELLS = GW * GH;

    logic        clock   = 1'b0;
    logic        clear_n = 1'b0;
    logic        go      = 1'b0;
    logic        busy;
    logic        done;
    logic        error;
    logic [15:0] result;

    aoc_grid_sequencer_if bus();

    aoc_grid_sequencer #(.GRID_W(GW), .GRID_H(GH), .POLL_LIMIT(PL)) dut (
        .clock   (clock),
        .clear_n (clear_n),
        .go      (go),
        .busy    (busy),
        .done    (done),
        .error   (error),
        .result  (result),
        .bus     (bus)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic [3:0]  addr;
        logic [31:0] wdata;
    } wr_t;

    typedef struct packed {
        logic [15:0] result;
        logic        error;
        logic [31:0] polls;
    } res_t;

    wr_t  exp_wr[$];
    res_t exp_res[$];
    int   checks = 0;
    int   errors = 0;

    int   tb_row, tb_col;
    logic tb_err;
    int   poll_cycles = 0;
    logic prev_done = 1'b0;
    logic poll_hit = 1'b0;

    // Behavioural solver: mode 0 fixed count, 1 computed removal count, 2 never finishes.
    logic        sv_ram [CELLS];
    logic [31:0] sv_idx = 32'd0;
    logic        sv_done = 1'b0;
    logic        sv_running = 1'b0;
    int          sv_polls = 0;
    logic [15:0] sv_count = 16'd0;
    int          sv_mode = 0;

    initial begin
        for (int i = 0; i < CELLS; i++) sv_ram[i] = 1'b0;
    end

    function automatic int count_removals();
        logic g [CELLS];
        logic rm [CELLS];
        int total;
        int removed;
        total = 0;
        for (int i = 0; i < CELLS; i++) g[i] = sv_ram[i];
        do begin
            removed = 0;
            for (int r = 0; r < GH; r++) begin
                for (int c = 0; c < GW; c++) begin
                    int n;
                    n = 0;
                    rm[r*GW+c] = 1'b0;
                    if (g[r*GW+c]) begin
                        for (int dr = -1; dr <= 1; dr++) begin
                            for (int dc = -1; dc <= 1; dc++) begin
                                if ((dr != 0 || dc != 0) && r+dr >= 0 && r+dr < GH &&
                                    c+dc >= 0 && c+dc < GW && g[(r+dr)*GW+(c+dc)]) n++;
                            end
                        end
                        if (n < 4) begin
                            rm[r*GW+c] = 1'b1;
                            removed++;
                        end
                    end
                end
            end
            for (int i = 0; i < CELLS; i++) if (rm[i]) g[i] = 1'b0;
            total += removed;
        end while (removed != 0);
        return total;
    endfunction

    assign bus.reg_rdata = (bus.reg_addr == 4'd1) ? {sv_count, 15'd0, sv_done} : 32'd0;

    // Solver register behaviour; solver_clear resets status but not the cell RAM.
    always @(posedge clock) begin
        if (bus.solver_clear) begin
            sv_done    <= 1'b0;
            sv_running <= 1'b0;
            sv_polls   <= 0;
        end else if (bus.reg_write_strobe) begin
            case (bus.reg_addr)
                4'd2: sv_idx <= bus.reg_wdata;
                4'd3: if (sv_idx < CELLS) sv_ram[sv_idx[6:0]] <= bus.reg_wdata[0];
                4'd0: if (bus.reg_wdata[0]) begin
                    sv_running <= 1'b1;
                    sv_polls   <= 0;
                    sv_done    <= 1'b0;
                    sv_count   <= (sv_mode == 1) ? 16'(count_removals()) : 16'h002A;
                end
                default: ;
            endcase
        end else if (sv_running && bus.reg_addr == 4'd1) begin
            if (sv_mode != 2 && sv_polls == 4) sv_done <= 1'b1;
            sv_polls <= sv_polls + 1;
        end
    end

    task checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: actual=0x%0h required=0x%0h", name, actual, expected);
        end
    endtask

    // Monitor: pops expected writes on every strobe and expected outcomes on done rising.
    always @(negedge clock) begin
        wr_t  e;
        res_t r;
        if (poll_hit) checkOutput("done_one_cycle_after_poll", {31'd0, done}, 32'd1);
        poll_hit = 1'b0;
        if (bus.reg_write_strobe === 1'b1) begin
            if (exp_wr.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL unexpected_write: addr=%0d wdata=0x%0h required=none",
                         bus.reg_addr, bus.reg_wdata);
            end else begin
                e = exp_wr.pop_front();
                checkOutput("write_addr", {28'd0, bus.reg_addr}, {28'd0, e.addr});
                checkOutput("write_data", bus.reg_wdata, e.wdata);
            end
        end
        if (busy === 1'b1 && bus.reg_addr == 4'd1 && bus.reg_write_strobe == 1'b0) begin
            poll_cycles++;
            if (bus.reg_rdata[0]) poll_hit = 1'b1;
        end
        if (done === 1'b1 && prev_done !== 1'b1) begin
            if (exp_res.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL unexpected_done: result=%0d required=none", result);
            end else begin
                r = exp_res.pop_front();
                checkOutput("job_result", {16'd0, result}, {16'd0, r.result});
                checkOutput("job_error", {31'd0, error}, {31'd0, r.error});
                checkOutput("poll_cycles", poll_cycles, r.polls);
            end
        end
        prev_done = done;
    end

    // Pulses go (at a negedge) and checks the go-to-in_ready latency.
    task start_job();
        int n;
        tb_row = 0;
        tb_col = 0;
        tb_err = 1'b0;
        poll_cycles = 0;
`ifdef AOC_GRID_SEQ_PREZERO_EN
        for (int i = 0; i < CELLS; i++) begin
            exp_wr.push_back('{4'd2, 32'(i)});
            exp_wr.push_back('{4'd3, 32'd0});
        end
`endif
        go = 1'b1;
        @(negedge clock);
        go = 1'b0;
        n = 1;
        while (!bus.in_ready && n < 5000) begin
            @(negedge clock);
            n++;
        end
`ifdef AOC_GRID_SEQ_PREZERO_EN
        checkOutput("go_to_in_ready", n, 2 + 2 * CELLS);
`else
        checkOutput("go_to_in_ready", n, 2);
`endif
    endtask

    // Sends one byte and queues the register writes that byte should produce.
    task applyStimulus(input logic [7:0] b, input logic last);
        int n;
        n = 0;
        if (b == 8'h40 || b == 8'h2E) begin
            if (tb_col < GW && tb_row < GH) begin
                exp_wr.push_back('{4'd2, 32'(tb_row * GW + tb_col)});
                exp_wr.push_back('{4'd3, {31'd0, (b == 8'h40)}});
                tb_col++;
            end else begin
                tb_err = 1'b1;
                if (tb_col < GW) tb_col++;
            end
        end else if (b == 8'h0A) begin
            tb_col = 0;
            if (tb_row < GH) tb_row++;
        end
        if (last) exp_wr.push_back('{4'd0, 32'd1});
        bus.in_valid = 1'b1;
        bus.in_data  = b;
        bus.in_last  = last;
        while (!bus.in_ready && n < 1000) begin
            @(negedge clock);
            n++;
        end
        if (n >= 1000) begin
            checks++;
            errors++;
            $display("[TB] FAIL in_handshake: in_ready=0 required=1 within 1000 cycles");
        end
        @(negedge clock);
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
    endtask

    task send_line(input string s, input logic last);
        for (int i = 0; i < s.len(); i++) applyStimulus(s[i], 1'b0);
        applyStimulus(8'h0A, last);
    endtask

    task wait_job(input logic [15:0] res, input logic err, input int polls);
        int n;
        exp_res.push_back('{res, err, 32'(polls)});
        n = 0;
        while (done !== 1'b1 && n < 2000) begin
            @(negedge clock);
            n++;
        end
        if (n >= 2000) begin
            checks++;
            errors++;
            $display("[TB] FAIL done_timeout: done=0 required=1 within 2000 cycles");
        end
        @(negedge clock);
        checkOutput("writes_drained", exp_wr.size(), 0);
        checkOutput("outcome_drained", exp_res.size(), 0);
        checkOutput("busy_in_done", {31'd0, busy}, 32'd0);
    endtask

    string grid [10] = '{
        "..@@.@@@@.", "@@@.@.@.@@", "@@@@@.@.@@", "@.@@@@..@.", "@@.@@@@.@@",
        ".@@@@@@@.@", ".@.@.@.@@@", "@.@@@.@@@@", ".@@@@@@@@.", "@.@.@@@.@."
    };

    initial begin
        bus.in_valid = 1'b0;
        bus.in_data  = 8'd0;
        bus.in_last  = 1'b0;
        repeat (3) @(negedge clock);

        // Reset values.
        checkOutput("rst_in_ready", {31'd0, bus.in_ready}, 32'd0);
        checkOutput("rst_busy", {31'd0, busy}, 32'd0);
        checkOutput("rst_done", {31'd0, done}, 32'd0);
        checkOutput("rst_error", {31'd0, error}, 32'd0);
        checkOutput("rst_result", {16'd0, result}, 32'd0);
        checkOutput("rst_solver_clear", {31'd0, bus.solver_clear}, 32'd0);
        checkOutput("rst_addr", {28'd0, bus.reg_addr}, 32'd0);
        checkOutput("rst_wdata", bus.reg_wdata, 32'd0);
        checkOutput("rst_strobe", {31'd0, bus.reg_write_strobe}, 32'd0);
        clear_n = 1'b1;
        @(negedge clock);

        // Reset while WR_ADDR is on the bus.
        $display("[TB] reset during WR_ADDR");
        start_job();
        applyStimulus(8'h40, 1'b0);
        checkOutput("mid_strobe_before_reset", {31'd0, bus.reg_write_strobe}, 32'd1);
        clear_n = 1'b0;
        @(negedge clock);
        clear_n = 1'b1;
        checkOutput("mid_rst_strobe", {31'd0, bus.reg_write_strobe}, 32'd0);
        checkOutput("mid_rst_busy", {31'd0, busy}, 32'd0);
        checkOutput("mid_rst_in_ready", {31'd0, bus.in_ready}, 32'd0);
        checkOutput("mid_rst_addr", {28'd0, bus.reg_addr}, 32'd0);
        exp_wr.delete();

        // Full example grid with the computing solver model.
        $display("[TB] example grid");
        sv_mode = 1;
        start_job();
        for (int i = 0; i < 10; i++) send_line(grid[i], i == 9);
        wait_job(16'd43, 1'b0, 6);

        // Single '@' with in_last, fixed count 0x2A.
        $display("[TB] single cell");
        sv_mode = 0;
        start_job();
        applyStimulus(8'h40, 1'b1);
        wait_job(16'd42, 1'b0, 6);
        repeat (3) @(negedge clock);
        checkOutput("done_held", {31'd0, done}, 32'd1);

        // Row overflow plus a go pulse while busy, which must be ignored.
        $display("[TB] row overflow");
        start_job();
        send_line("@.@.@.@.@.@", 1'b0);
        go = 1'b1;
        @(negedge clock);
        go = 1'b0;
        checkOutput("go_while_busy_ignored", {31'd0, busy}, 32'd1);
        send_line("@@", 1'b1);
        wait_job(16'd42, 1'b1, 6);

        // Solver never finishes: timeout after POLL_LIMIT polls.
        $display("[TB] poll timeout");
        sv_mode = 2;
        start_job();
        applyStimulus(8'h2E, 1'b1);
        wait_job(16'd0, 1'b1, PL);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
